// File: rtl/restoring_divider_8.sv
// Sequential unsigned restoring divider: one quotient bit per clock over WIDTH compute cycles.
// A start in IDLE either enters COMPUTE or, for a zero divisor, goes straight to DONE with saturated results.
module restoring_divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   t;
    logic [SW-1:0]    sum;
    logic             c;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_r_msb;

    // The top bit of R is always zero between iterations because R < D.
    assign unused_r_msb = r[WIDTH];

    // Trial subtract as T + ~{0,D} + 1; the extra top bit is the no-borrow carry.
    always_comb begin
        t      = {r[WIDTH-1:0], q[WIDTH-1]};
        sum    = {1'b0, t} + {1'b0, ~{1'b0, d}} + SW'(1);
        c      = sum[SW-1];
        r_next = c ? sum[WIDTH:0] : t;
        q_next = {q[WIDTH-2:0], c};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            d         <= '0;
            q         <= '0;
            r         <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        d     <= Divisor;
                        q     <= Dividend;
                        r     <= '0;
                        count <= '0;
                        if (Divisor == '0) begin
                            state     <= S_DONE;
                            Done      <= 1'b1;
                            DivByZero <= 1'b1;
                            Quotient  <= '1;
                            Remainder <= Dividend;
                        end else begin
                            state     <= S_COMPUTE;
                            Busy      <= 1'b1;
                            DivByZero <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    q     <= q_next;
                    r     <= r_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        Quotient  <= q_next;
                        Remainder <= r_next[WIDTH-1:0];
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    // A held Run keeps us here so one request yields one result.
                    if (!Run) begin
                        state <= S_IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_8.sv
// Randomized and directed bench for restoring_divider_8 against a plain-arithmetic division model.
module tb_restoring_divider_8;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int checks = 0;
    int errors = 0;

    restoring_divider_8 #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: plain unsigned division with the zero-divisor convention.
    function automatic void model(input int unsigned dvd, input int unsigned dvs,
                                  output int unsigned eq, output int unsigned er,
                                  output bit ez);
        if (dvs == 0) begin
            eq = (1 << W) - 1;
            er = dvd;
            ez = 1'b1;
        end else begin
            eq = dvd / dvs;
            er = dvd % dvs;
            ez = 1'b0;
        end
    endfunction

    // Returns to IDLE, issues one request and waits (bounded) for Done.
    // edges counts clock edges from the Run edge (1) to the edge after which Done is seen.
    task automatic divide(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit hold_run,
                          output int edges, output int busy_cnt, output bit timed_out);
        Run = 1'b0;
        tick();
        Dividend = dvd;
        Divisor  = dvs;
        Run      = 1'b1;
        tick();
        edges    = 1;
        busy_cnt = 0;
        if (!hold_run) Run = 1'b0;
        while (!Done && edges < 40) begin
            if (Busy) busy_cnt++;
            tick();
            edges++;
        end
        timed_out = !Done;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b1;
        tick();
        tick();
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/dz=%b expected 000", {Busy, Done, DivByZero});
        end
        checks++;
        if (Quotient !== '0 || Remainder !== '0) begin
            errors++;
            $display("FAIL reset_results: q=%0d r=%0d expected 0 0", Quotient, Remainder);
        end
        Reset = 1'b0;
        Run   = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e, b;
        bit to;
        divide(8'd100, 8'd7, 1'b0, e, b, to);
        checks++;
        if (to || e != 9) begin
            errors++;
            $display("FAIL basic_latency: done after edge %0d (timeout=%0d) expected 9", e, to);
        end
        checks++;
        if (b != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: %0d expected 8", b);
        end
        checks++;
        if (Quotient !== 8'd14 || Remainder !== 8'd2 || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b expected 14 2 0", Quotient, Remainder, DivByZero);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] dv [5] = '{8'd255, 8'd255, 8'd5, 8'd0, 8'd254};
        logic [W-1:0] ds [5] = '{8'd1, 8'd255, 8'd10, 8'd13, 8'd255};
        int unsigned eq, er;
        bit ez, to;
        int e, b;
        for (int i = 0; i < 5; i++) begin
            model(dv[i], ds[i], eq, er, ez);
            divide(dv[i], ds[i], 1'b0, e, b, to);
            checks++;
            if (to || Quotient !== eq[W-1:0] || Remainder !== er[W-1:0] || DivByZero !== ez) begin
                errors++;
                $display("FAIL corner_%0d_%0d: q=%0d r=%0d dz=%b expected %0d %0d %0d",
                         dv[i], ds[i], Quotient, Remainder, DivByZero, eq, er, ez);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, b;
        bit to;
        divide(8'd42, 8'd0, 1'b0, e, b, to);
        checks++;
        if (to || e != 1 || b != 0) begin
            errors++;
            $display("FAIL divzero_timing: done edge %0d busy cycles %0d expected 1 0", e, b);
        end
        checks++;
        if (DivByZero !== 1'b1 || Quotient !== 8'd255 || Remainder !== 8'd42) begin
            errors++;
            $display("FAIL divzero_result: dz=%b q=%0d r=%0d expected 1 255 42", DivByZero, Quotient, Remainder);
        end
    endtask

    task automatic test_reset_mid();
        int e, b;
        bit to;
        Run = 1'b0;
        tick();
        Dividend = 8'd200;
        Divisor  = 8'd3;
        Run      = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000 || Quotient !== '0 || Remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy/done/dz=%b q=%0d r=%0d expected 000 0 0",
                     {Busy, Done, DivByZero}, Quotient, Remainder);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b done=%b expected 0 0", Busy, Done);
        end
        divide(8'd200, 8'd3, 1'b0, e, b, to);
        checks++;
        if (to || Quotient !== 8'd66 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL reset_mid_rerun: q=%0d r=%0d expected 66 2", Quotient, Remainder);
        end
    endtask

    task automatic test_hold_run();
        int e, b;
        bit to;
        divide(8'd50, 8'd6, 1'b1, e, b, to);
        checks++;
        if (to || Quotient !== 8'd8 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL hold_result: q=%0d r=%0d expected 8 2", Quotient, Remainder);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Done !== 1'b1 || Busy !== 1'b0 || Quotient !== 8'd8) begin
                errors++;
                $display("FAIL hold_stay_%0d: done=%b busy=%b q=%0d expected 1 0 8", i, Done, Busy, Quotient);
            end
        end
        Run = 1'b0;
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== 8'd8 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL hold_release: done=%b busy=%b q=%0d r=%0d expected 0 0 8 2",
                     Done, Busy, Quotient, Remainder);
        end
        divide(8'd9, 8'd4, 1'b0, e, b, to);
        checks++;
        if (to || Quotient !== 8'd2 || Remainder !== 8'd1) begin
            errors++;
            $display("FAIL hold_rerun: q=%0d r=%0d expected 2 1", Quotient, Remainder);
        end
    endtask

    task automatic test_input_change();
        int n;
        Run = 1'b0;
        tick();
        Dividend = 8'd77;
        Divisor  = 8'd5;
        Run      = 1'b1;
        tick();
        n = 1;
        while (!Done && n < 40) begin
            Dividend = W'($urandom);
            Divisor  = W'($urandom);
            Run      = 1'($urandom);
            tick();
            n++;
        end
        checks++;
        if (!Done || Quotient !== 8'd15 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL input_change: done=%b q=%0d r=%0d expected 1 15 2", Done, Quotient, Remainder);
        end
    endtask

    task automatic test_random();
        int unsigned eq, er;
        bit ez, to;
        int e, b;
        logic [W-1:0] dvd, dvs;
        for (int i = 0; i < 200; i++) begin
            dvd = W'($urandom);
            dvs = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            model(dvd, dvs, eq, er, ez);
            divide(dvd, dvs, 1'($urandom), e, b, to);
            checks++;
            if (to || Quotient !== eq[W-1:0] || Remainder !== er[W-1:0] || DivByZero !== ez
                || e != (ez ? 1 : 9)) begin
                errors++;
                $display("FAIL random_%0d_%0d: q=%0d r=%0d dz=%b edges=%0d expected %0d %0d %0d %0d",
                         dvd, dvs, Quotient, Remainder, DivByZero, e, eq, er, ez, ez ? 1 : 9);
            end
            if (dvs != 0) begin
                checks++;
                if (int'(Quotient) * int'(dvs) + int'(Remainder) != int'(dvd) || Remainder >= dvs) begin
                    errors++;
                    $display("FAIL random_invariant_%0d_%0d: q=%0d r=%0d", dvd, dvs, Quotient, Remainder);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_reset_mid();
        test_hold_run();
        test_input_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
